// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between the SPI slave receive FIFO and the register bus.
// Parses {rw, addr} command bytes (plus a data byte for writes) into single-cycle bus strobes.
module spi_cmd_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_WIDTH       = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic [7:0]            tx_data,
  output logic                  frame_err,
  output logic [15:0]           frame_count
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [BYTE_W-1:0]   TX_IDLE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD_WAIT,
    DECODE,
    RD_WAIT,
    DATA_POLL,
    DATA_WAIT,
    WRITE
  } state_t;

  state_t              state;
  logic [BYTE_W-1:0]   cmd;
  logic [TO_WIDTH-1:0] to_cnt;

  // Frame sequencer; strobes default low so each is a one-cycle pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd         <= '0;
      to_cnt      <= '0;
      fifo_rd_en  <= 1'b0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      tx_data     <= TX_IDLE;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            state      <= CMD_WAIT;
          end
        end
        CMD_WAIT: begin
          cmd   <= fifo_data;
          state <= DECODE;
        end
        DECODE: begin
          if (!cmd[BYTE_W-1]) begin
            reg_addr <= cmd[ADDR_WIDTH-1:0];
            reg_re   <= 1'b1;
            state    <= RD_WAIT;
          end else begin
            to_cnt <= '0;
            state  <= DATA_POLL;
          end
        end
        RD_WAIT: begin
          tx_data     <= reg_rdata;
          frame_count <= frame_count + CNT_W'(1);
          state       <= IDLE;
        end
        DATA_POLL: begin
          if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            to_cnt     <= '0;
            state      <= DATA_WAIT;
          end else if (to_cnt == TO_LAST) begin
            // Data byte never arrived: drop the command without touching the bus.
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
          end
        end
        DATA_WAIT: begin
          reg_wdata <= fifo_data;
          reg_addr  <= cmd[ADDR_WIDTH-1:0];
          state     <= WRITE;
        end
        WRITE: begin
          reg_we      <= 1'b1;
          tx_data     <= reg_wdata;
          frame_count <= frame_count + CNT_W'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: FIFO and register-bus models, directed and random frames.
module tb_spi_cmd_ctrl;

  localparam int unsigned TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fifo_data = 8'hEE;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [6:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata = 8'h00;
  logic [7:0]  tx_data;
  logic        frame_err;
  logic [15:0] frame_count;

  spi_cmd_ctrl #(.ADDR_WIDTH(7), .TIMEOUT_CYCLES(TO), .TO_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .tx_data(tx_data), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        wr;
    bit [6:0]  addr;
    bit [7:0]  data;
    bit [15:0] cnt;
    bit        err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       rd_exp;
  logic [7:0] fifo_q[$];
  logic [7:0] model_mem[128];
  logic [7:0] bus_mem[128];
  int         pop_log[$], re_log[$], we_log[$];
  int         cyc = 0, errors = 0, checks = 0;
  bit         rd_pending = 0, empty_prev = 1, rd_s = 0, prev_we = 0, prev_re = 0;
  logic [15:0] model_cnt = 0;
  bit         model_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic void fifo_drive();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'hEE;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_drive();
  endtask

  task automatic sync();
    @(posedge clock);
    #2;
  endtask

  task automatic issue_read(input logic [6:0] a);
    exp_t e;
    model_cnt++;
    e.wr = 0; e.addr = a; e.data = model_mem[a]; e.cnt = model_cnt; e.err = model_err;
    exp_q.push_back(e);
    push({1'b0, a});
  endtask

  task automatic issue_write(input logic [6:0] a, input logic [7:0] d, input int gap);
    exp_t e;
    model_mem[a] = d;
    model_cnt++;
    e.wr = 1; e.addr = a; e.data = d; e.cnt = model_cnt; e.err = model_err;
    exp_q.push_back(e);
    push({1'b1, a});
    repeat (gap) sync();
    push(d);
  endtask

  task automatic issue_abort(input logic [6:0] a);
    model_err = 1;
    push({1'b1, a});
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !rd_pending) begin
        done = 1;
        break;
      end
      @(posedge clock);
    end
    chk("drain", 32'(done), 32'd1);
    repeat (8) @(posedge clock);
  endtask

  task automatic clear_logs();
    pop_log.delete();
    re_log.delete();
    we_log.delete();
  endtask

  initial forever @(posedge clock) cyc++;

  // FIFO: first-word-fall-through head, popped just after the edge that saw fifo_rd_en.
  initial forever begin
    @(negedge clock);
    rd_s = fifo_rd_en;
    @(posedge clock);
    #1;
    if (rd_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fifo_drive();
  end

  // Register bus: read data present only in the cycle following the read strobe's edge.
  initial forever begin
    @(posedge clock);
    #1;
    if (reg_we) bus_mem[reg_addr] = reg_wdata;
    reg_rdata = reg_re ? bus_mem[reg_addr] : 8'($urandom);
  end

  // Monitor: compares every bus strobe against the next scoreboard entry.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (reset) begin
      rd_pending = 0;
      prev_we = 0;
      prev_re = 0;
    end else begin
      if (rd_pending) begin
        rd_pending = 0;
        chk("rd_tx_data", 32'(tx_data), 32'(rd_exp.data));
        chk("rd_frame_count", 32'(frame_count), 32'(rd_exp.cnt));
        chk("rd_frame_err", 32'(frame_err), 32'(rd_exp.err));
      end
      if (fifo_rd_en) begin
        chk("pop_while_empty", 32'(empty_prev), 32'd0);
        pop_log.push_back(cyc);
      end
      if (reg_re || reg_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: re=%0b we=%0b addr=%0h, expected no strobe (cycle %0d)",
                   reg_re, reg_we, reg_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind_we", 32'(reg_we), 32'(e.wr));
          chk("strobe_kind_re", 32'(reg_re), 32'(!e.wr));
          chk("strobe_addr", 32'(reg_addr), 32'(e.addr));
          if (reg_we) begin
            chk("we_single", 32'(prev_we), 32'd0);
            chk("we_wdata", 32'(reg_wdata), 32'(e.data));
            chk("we_tx_echo", 32'(tx_data), 32'(e.data));
            chk("we_frame_count", 32'(frame_count), 32'(e.cnt));
            chk("we_frame_err", 32'(frame_err), 32'(e.err));
            we_log.push_back(cyc);
          end else begin
            chk("re_single", 32'(prev_re), 32'd0);
            rd_pending = 1;
            rd_exp = e;
            re_log.push_back(cyc);
          end
        end
      end
      prev_we = reg_we;
      prev_re = reg_re;
    end
    empty_prev = fifo_empty;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, "_we"}, 32'(reg_we), 32'd0);
    chk({tag, "_re"}, 32'(reg_re), 32'd0);
    chk({tag, "_addr"}, 32'(reg_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    chk({tag, "_tx"}, 32'(tx_data), 32'hA5);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    bit   kinds[8];
    int   expo[$];
    int   off;
    logic [7:0] v;

    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      model_mem[i] = v;
      bus_mem[i] = v;
    end
    model_mem[5] = 8'h3C;
    bus_mem[5] = 8'h3C;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;

    // Single read frame and its latency.
    clear_logs();
    sync();
    issue_read(7'h05);
    wait_idle();
    chk("t1_pops", 32'(pop_log.size()), 32'd1);
    chk("t1_reads", 32'(re_log.size()), 32'd1);
    chk("t1_writes", 32'(we_log.size()), 32'd0);
    if (re_log.size() == 1 && pop_log.size() == 1)
      chk("t1_re_latency", 32'(re_log[0] - pop_log[0]), 32'd2);

    // Write frame with data already buffered.
    clear_logs();
    sync();
    issue_write(7'h05, 8'h77, 0);
    wait_idle();
    chk("t2_pops", 32'(pop_log.size()), 32'd2);
    chk("t2_writes", 32'(we_log.size()), 32'd1);
    chk("t2_reads", 32'(re_log.size()), 32'd0);
    if (pop_log.size() == 2 && we_log.size() == 1) begin
      chk("t2_data_pop_gap", 32'(pop_log[1] - pop_log[0]), 32'd3);
      chk("t2_we_latency", 32'(we_log[0] - pop_log[0]), 32'd5);
    end

    // Late data byte, still inside the timeout window.
    sync();
    issue_write(7'h01, 8'hAB, 10);
    wait_idle();
    chk("t4_no_err", 32'(frame_err), 32'd0);

    // Timeout abort, then a normal read.
    sync();
    issue_abort(7'h10);
    repeat (40) @(posedge clock);
    chk("t3_err_set", 32'(frame_err), 32'd1);
    sync();
    issue_read(7'h01);
    wait_idle();

    // Eight preloaded frames, shuffled 4 reads / 4 writes.
    for (int i = 0; i < 8; i++) kinds[i] = (i < 4);
    for (int i = 7; i > 0; i--) begin
      int j = $urandom_range(0, i);
      bit t = kinds[i];
      kinds[i] = kinds[j];
      kinds[j] = t;
    end
    clear_logs();
    sync();
    off = 0;
    for (int i = 0; i < 8; i++) begin
      expo.push_back(off);
      if (kinds[i]) begin
        issue_write(7'($urandom_range(0, 15)), 8'($urandom), 0);
        expo.push_back(off + 3);
        off += 6;
      end else begin
        issue_read(7'($urandom_range(0, 15)));
        off += 4;
      end
    end
    wait_idle();
    chk("t5_pops", 32'(pop_log.size()), 32'(expo.size()));
    if (pop_log.size() == expo.size())
      for (int i = 1; i < expo.size(); i++)
        chk("t5_pop_spacing", 32'(pop_log[i] - pop_log[0]), 32'(expo[i]));
    chk("t5_frame_count", 32'(frame_count), 32'(model_cnt));

    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      int sel = $urandom_range(0, 9);
      sync();
      if (sel < 6) begin
        int n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          if ($urandom_range(0, 1) == 1)
            issue_write(7'($urandom_range(0, 15)), 8'($urandom), 0);
          else
            issue_read(7'($urandom_range(0, 15)));
        end
      end else if (sel < 9) begin
        issue_write(7'($urandom_range(0, 15)), 8'($urandom), $urandom_range(1, 8));
      end else begin
        wait_idle();
        sync();
        issue_abort(7'($urandom_range(0, 15)));
        repeat (40) @(posedge clock);
        chk("rand_abort_err", 32'(frame_err), 32'd1);
      end
    end
    wait_idle();
    chk("rand_frame_count", 32'(frame_count), 32'(model_cnt));
    chk("rand_frame_err", 32'(frame_err), 32'(model_err));

    // Reset while waiting for a write data byte.
    sync();
    push(8'h82);
    repeat (6) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    model_cnt = 0;
    model_err = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sync();
    issue_read(7'h03);
    wait_idle();
    chk("post_reset_count", 32'(frame_count), 32'd1);
    chk("post_reset_err", 32'(frame_err), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
